// File: rtl/vc_pop_scheduler_pkg.sv
// vc_pop_scheduler_pkg
//   Shared definitions for the VC pop scheduler, its round-robin search
//   and the downstream demux: FSM state encoding, VC index constants and
//   one-hot/index conversion helpers.
package vc_pop_scheduler_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_t;

  localparam int VC_COUNT = 4;

  localparam logic [1:0] VCHANEL0 = 2'b00;
  localparam logic [1:0] VCHANEL1 = 2'b01;
  localparam logic [1:0] VCHANEL2 = 2'b10;
  localparam logic [1:0] VCHANEL3 = 2'b11;

  // VC index -> one-hot pop strobe.
  function automatic logic [3:0] vc_onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  // One-hot pop strobe -> VC index; an all-zero strobe maps to VCHANEL0.
  function automatic logic [1:0] vc_index(input logic [3:0] oh);
    logic [1:0] idx;
    idx = VCHANEL0;
    case (oh)
      4'b0010: idx = VCHANEL1;
      4'b0100: idx = VCHANEL2;
      4'b1000: idx = VCHANEL3;
      default: idx = VCHANEL0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/vc_pop_scheduler_rr_next_vc.sv
// rr_next_vc
//   Combinational rotating search: returns the first set bit of the
//   eligibility mask, looking from start upward and wrapping modulo 4.
//   Ports:
//     elig  - per-VC eligibility mask
//     start - index searched first
//     idx   - selected VC (equals start when nothing is found)
//     found - at least one VC is eligible
module rr_next_vc
  import vc_pop_scheduler_pkg::*;
(
  input  logic [3:0] elig,
  input  logic [1:0] start,
  output logic [1:0] idx,
  output logic       found
);

  logic [1:0] cand;

  // Walk offsets from farthest to nearest so the nearest eligible VC wins.
  always_comb begin
    idx   = start;
    found = 1'b0;
    cand  = start;
    for (int k = VC_COUNT - 1; k >= 0; k--) begin
      cand = start + 2'(k);
      if (elig[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vc_pop_scheduler.sv
// vc_pop_scheduler
//   Weighted round-robin pop scheduler for four virtual-channel FIFOs.
//   Each turn grants up to weightN consecutive pops to one VC, then hands
//   off to the next eligible VC (rotating from the served VC + 1) with no
//   idle cycle in between.
//   Ports:
//     clk, rst      - clock, asynchronous active-high reset
//     enb           - enable; low freezes scheduling state and blocks pops
//     fifo_empty    - per-VC FIFO empty flags
//     dest_afull    - per-VC downstream almost-full flags
//     weight0..3    - pops per turn for each VC (0 disables the VC)
//     pop           - registered one-hot FIFO read strobe
//     arbiter       - registered index of the VC whose data is on the mux
//     valid_out     - registered; mux carries popped data
//     busy          - registered; FSM is in SERVE
//
//   Strobe semantics: pop is a one-cycle, fire-and-forget read strobe with
//   no back-pressure. Flags sampled at edge n produce pop in cycle n+1; the
//   FIFO returns data one cycle later, which valid_out/arbiter mark in
//   cycle n+2. A flag raised in the same cycle as a pop can therefore see
//   one surplus pop, which the FIFO/destination must absorb.
module vc_pop_scheduler
  import vc_pop_scheduler_pkg::*;
#(
  parameter int WEIGHT_W = 3,
  parameter int NUM_VC   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enb,
  input  logic [3:0]          fifo_empty,
  input  logic [3:0]          dest_afull,
  input  logic [WEIGHT_W-1:0] weight0,
  input  logic [WEIGHT_W-1:0] weight1,
  input  logic [WEIGHT_W-1:0] weight2,
  input  logic [WEIGHT_W-1:0] weight3,
  output logic [3:0]          pop,
  output logic [1:0]          arbiter,
  output logic                valid_out,
  output logic                busy
);

  logic [WEIGHT_W-1:0] weights [NUM_VC];
  logic [NUM_VC-1:0]   elig;

  state_t              state, state_next;
  logic [1:0]          cur, cur_next;
  logic [1:0]          ptr, ptr_next;
  logic [WEIGHT_W-1:0] credit, credit_next;
  logic [3:0]          pop_next;

  logic [1:0]          search_start;
  logic [1:0]          sel;
  logic                sel_found;
  logic                keep;

  assign weights[0] = weight0;
  assign weights[1] = weight1;
  assign weights[2] = weight2;
  assign weights[3] = weight3;

  always_comb begin
    for (int i = 0; i < NUM_VC; i++) begin
      elig[i] = ~fifo_empty[i] & ~dest_afull[i] & (weights[i] != '0);
    end
  end

  // IDLE resumes from the rotating pointer; a SERVE handoff searches from
  // the VC after the current one, which lets the current VC be reselected
  // last when it is the only one left.
  assign search_start = (state == IDLE) ? ptr : cur + 2'd1;

  rr_next_vc u_rr_next_vc (
    .elig  (elig),
    .start (search_start),
    .idx   (sel),
    .found (sel_found)
  );

  // Current VC still owns the turn: eligible with pops remaining.
  assign keep = (state == SERVE) && elig[cur] && (credit != '0);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cur    <= VCHANEL0;
      ptr    <= VCHANEL0;
      credit <= '0;
    end else begin
      state  <= state_next;
      cur    <= cur_next;
      ptr    <= ptr_next;
      credit <= credit_next;
    end
  end

  // Next-state logic. In SERVE, credit counts pops still owed after the
  // one being issued now; a handoff issues the new VC's first pop in the
  // same cycle, hence the reload of weight - 1 (weight is nonzero because
  // the selected VC is eligible).
  always_comb begin
    state_next  = state;
    cur_next    = cur;
    ptr_next    = ptr;
    credit_next = credit;
    if (enb) begin
      case (state)
        IDLE: begin
          if (sel_found) begin
            state_next  = SERVE;
            cur_next    = sel;
            credit_next = weights[sel];
          end
        end
        SERVE: begin
          if (keep) begin
            credit_next = credit - WEIGHT_W'(1);
          end else begin
            ptr_next = cur + 2'd1;
            if (sel_found) begin
              cur_next    = sel;
              credit_next = weights[sel] - WEIGHT_W'(1);
            end else begin
              state_next  = IDLE;
              credit_next = '0;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Output logic: the strobe to be registered for the coming cycle.
  always_comb begin
    pop_next = 4'b0000;
    if (enb && (state == SERVE)) begin
      if (keep) begin
        pop_next = vc_onehot(cur);
      end else if (sel_found) begin
        pop_next = vc_onehot(sel);
      end
    end
  end

  // Registered outputs; valid_out/arbiter trail pop by one cycle to match
  // the FIFO read latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pop       <= 4'b0000;
      arbiter   <= VCHANEL0;
      valid_out <= 1'b0;
      busy      <= 1'b0;
    end else begin
      pop       <= pop_next;
      arbiter   <= vc_index(pop);
      valid_out <= |pop;
      busy      <= (state_next == SERVE);
    end
  end

endmodule

// File: tb/tb_vc_pop_scheduler.sv
module tb_vc_pop_scheduler;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enb = 1'b1;
  logic [3:0] fifo_empty = 4'hF;
  logic [3:0] dest_afull = 4'h0;
  logic [2:0] weight0 = '0, weight1 = '0, weight2 = '0, weight3 = '0;
  logic [3:0] pop;
  logic [1:0] arbiter;
  logic       valid_out;
  logic       busy;

  always #5 clk = ~clk;

  vc_pop_scheduler #(.WEIGHT_W(3), .NUM_VC(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .enb        (enb),
    .fifo_empty (fifo_empty),
    .dest_afull (dest_afull),
    .weight0    (weight0),
    .weight1    (weight1),
    .weight2    (weight2),
    .weight3    (weight3),
    .pop        (pop),
    .arbiter    (arbiter),
    .valid_out  (valid_out),
    .busy       (busy)
  );

  // ---------------- vectors / scoreboard ----------------
  typedef struct {
    logic        start;     // reset before applying this vector
    logic        enb;
    logic [3:0]  fe;
    logic [3:0]  af;
    logic [11:0] w;         // {w3, w2, w1, w0}
    logic [3:0]  exp_pop;   // pop expected after the next edge
    logic        exp_busy;
  } vec_t;

  vec_t       tbl[$];
  logic [7:0] exp_q[$];     // {busy, valid_out, arbiter, pop}
  logic [3:0] prev_pop;
  int         checks = 0;
  int         errors = 0;

  localparam logic [11:0] W_A = {3'd1, 3'd1, 3'd1, 3'd2};
  localparam logic [11:0] W_B = {3'd1, 3'd3, 3'd1, 3'd1};
  localparam logic [11:0] W_C = {3'd0, 3'd1, 3'd1, 3'd1};
  localparam logic [11:0] W_D = {3'd1, 3'd1, 3'd3, 3'd1};
  localparam logic [11:0] W_F = {3'd2, 3'd2, 3'd2, 3'd2};

  function automatic vec_t mk(input logic s, input logic e, input logic [3:0] fe,
                              input logic [3:0] af, input logic [11:0] w,
                              input logic [3:0] p, input logic b);
    vec_t v;
    v.start = s; v.enb = e; v.fe = fe; v.af = af; v.w = w;
    v.exp_pop = p; v.exp_busy = b;
    return v;
  endfunction

  function automatic logic [1:0] tb_enc(input logic [3:0] oh);
    case (oh)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, " pop"},     {4'b0, pop},       8'h00);
    check({tag, " arbiter"}, {6'b0, arbiter},   8'h00);
    check({tag, " valid"},   {7'b0, valid_out}, 8'h00);
    check({tag, " busy"},    {7'b0, busy},      8'h00);
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    enb = 1'b1; fifo_empty = 4'hF; dest_afull = 4'h0;
    {weight3, weight2, weight1, weight0} = '0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_zero_outputs("reset async");
    @(posedge clk);
    @(posedge clk);
    #1;
    check_zero_outputs("reset held");
    @(negedge clk);
    rst = 1'b0;
    prev_pop = 4'b0;
    exp_q.delete();
  endtask

  task automatic step(input vec_t v, input string tag);
    logic [7:0] e;
    enb = v.enb; fifo_empty = v.fe; dest_afull = v.af;
    {weight3, weight2, weight1, weight0} = v.w;
    exp_q.push_back({v.exp_busy, |prev_pop, tb_enc(prev_pop), v.exp_pop});
    prev_pop = v.exp_pop;
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check({tag, " pop"},     {4'b0, pop},       {4'b0, e[3:0]});
    check({tag, " arbiter"}, {6'b0, arbiter},   {6'b0, e[5:4]});
    check({tag, " valid"},   {7'b0, valid_out}, {7'b0, e[6]});
    check({tag, " busy"},    {7'b0, busy},      {7'b0, e[7]});
    check({tag, " onehot"},  {7'b0, ($countones(pop) <= 1)}, 8'h01);
  endtask

  // ---------------- test ----------------
  initial begin
    prev_pop = 4'b0;

    // A: weights 2,1,1,1, everything eligible -> 0,0,1,2,3,0,0,1,...
    tbl.push_back(mk(1, 1, 4'h0, 4'h0, W_A, 4'b0000, 1));
    tbl.push_back(mk(0, 1, 4'h0, 4'h0, W_A, 4'b0001, 1));
    tbl.push_back(mk(0, 1, 4'h0, 4'h0, W_A, 4'b0001, 1));
    tbl.push_back(mk(0, 1, 4'h0, 4'h0, W_A, 4'b0010, 1));
    tbl.push_back(mk(0, 1, 4'h0, 4'h0, W_A, 4'b0100, 1));
    tbl.push_back(mk(0, 1, 4'h0, 4'h0, W_A, 4'b1000, 1));
    tbl.push_back(mk(0, 1, 4'h0, 4'h0, W_A, 4'b0001, 1));
    tbl.push_back(mk(0, 1, 4'h0, 4'h0, W_A, 4'b0001, 1));
    tbl.push_back(mk(0, 1, 4'h0, 4'h0, W_A, 4'b0010, 1));
    tbl.push_back(mk(0, 1, 4'h0, 4'h0, W_A, 4'b0100, 1));
    // B: only VC2 non-empty, weight2=3 -> unbroken pop[2] across reloads
    tbl.push_back(mk(1, 1, 4'b1011, 4'h0, W_B, 4'b0000, 1));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(0, 1, 4'b1011, 4'h0, W_B, 4'b0100, 1));
    // C: weight3=0 -> VC3 skipped, 0,1,2 rotate
    tbl.push_back(mk(1, 1, 4'h0, 4'h0, W_C, 4'b0000, 1));
    tbl.push_back(mk(0, 1, 4'h0, 4'h0, W_C, 4'b0001, 1));
    tbl.push_back(mk(0, 1, 4'h0, 4'h0, W_C, 4'b0010, 1));
    tbl.push_back(mk(0, 1, 4'h0, 4'h0, W_C, 4'b0100, 1));
    tbl.push_back(mk(0, 1, 4'h0, 4'h0, W_C, 4'b0001, 1));
    tbl.push_back(mk(0, 1, 4'h0, 4'h0, W_C, 4'b0010, 1));
    tbl.push_back(mk(0, 1, 4'h0, 4'h0, W_C, 4'b0100, 1));
    // D: dest_afull[1] raised while VC1 served -> handoff to VC2; then all
    //    empty -> IDLE; refill -> restart from ptr (VC0)
    tbl.push_back(mk(1, 1, 4'h0, 4'h0,    W_D, 4'b0000, 1));
    tbl.push_back(mk(0, 1, 4'h0, 4'h0,    W_D, 4'b0001, 1));
    tbl.push_back(mk(0, 1, 4'h0, 4'h0,    W_D, 4'b0010, 1));
    tbl.push_back(mk(0, 1, 4'h0, 4'b0010, W_D, 4'b0100, 1));
    tbl.push_back(mk(0, 1, 4'h0, 4'b0010, W_D, 4'b1000, 1));
    tbl.push_back(mk(0, 1, 4'h0, 4'b0010, W_D, 4'b0001, 1));
    tbl.push_back(mk(0, 1, 4'h0, 4'b0010, W_D, 4'b0100, 1));
    tbl.push_back(mk(0, 1, 4'h0, 4'b0010, W_D, 4'b1000, 1));
    tbl.push_back(mk(0, 1, 4'hF, 4'h0,    W_D, 4'b0000, 0));
    tbl.push_back(mk(0, 1, 4'hF, 4'h0,    W_D, 4'b0000, 0));
    tbl.push_back(mk(0, 1, 4'h0, 4'h0,    W_D, 4'b0000, 1));
    tbl.push_back(mk(0, 1, 4'h0, 4'h0,    W_D, 4'b0001, 1));

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].start) do_reset();
      step(tbl[i], $sformatf("v%0d", i));
    end

    // E: enb low for 5 cycles with one pop of VC0 still owed
    do_reset();
    step(mk(0, 1, 4'h0, 4'h0, W_A, 4'b0000, 1), "enb c1");
    step(mk(0, 1, 4'h0, 4'h0, W_A, 4'b0001, 1), "enb c2");
    for (int i = 0; i < 5; i++)
      step(mk(0, 0, 4'h0, 4'h0, W_A, 4'b0000, 1), $sformatf("enb off%0d", i));
    step(mk(0, 1, 4'h0, 4'h0, W_A, 4'b0001, 1), "enb resume");
    step(mk(0, 1, 4'h0, 4'h0, W_A, 4'b0010, 1), "enb handoff");
    step(mk(0, 1, 4'h0, 4'h0, W_A, 4'b0100, 1), "enb next");

    // F: reset pulse while VC2 is mid-turn; restart from VC0 priority
    do_reset();
    step(mk(0, 1, 4'h0, 4'h0, W_F, 4'b0000, 1), "rstm c1");
    step(mk(0, 1, 4'h0, 4'h0, W_F, 4'b0001, 1), "rstm c2");
    step(mk(0, 1, 4'h0, 4'h0, W_F, 4'b0001, 1), "rstm c3");
    step(mk(0, 1, 4'h0, 4'h0, W_F, 4'b0010, 1), "rstm c4");
    step(mk(0, 1, 4'h0, 4'h0, W_F, 4'b0010, 1), "rstm c5");
    step(mk(0, 1, 4'h0, 4'h0, W_F, 4'b0100, 1), "rstm c6");
    #3;
    rst = 1'b1;
    #1;
    check_zero_outputs("rst mid async");
    @(posedge clk);
    @(posedge clk);
    #1;
    check_zero_outputs("rst mid held");
    @(negedge clk);
    rst = 1'b0;
    prev_pop = 4'b0;
    step(mk(0, 1, 4'b0001, 4'h0, W_F, 4'b0000, 1), "post c1");
    step(mk(0, 1, 4'b0001, 4'h0, W_F, 4'b0010, 1), "post c2");
    step(mk(0, 1, 4'b0001, 4'h0, W_F, 4'b0010, 1), "post c3");
    step(mk(0, 1, 4'b0001, 4'h0, W_F, 4'b0100, 1), "post c4");

    check("scoreboard drained", 8'(exp_q.size()), 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
